// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: owns fetch PC, per-stage valid bits, stage enables and event counters.
// Latency: enables/retire are combinational from the current inputs; PC, valids and counters update on the next clk edge.
// Backpressure: mem_busy freezes every stage; redirects seen while frozen are latched and applied on release.
module pipeline_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             imem_ready,
  input  logic             mem_busy,
  output logic [31:0]      pc_q,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_valid,
  output logic             id_ex_valid,
  output logic             ex_mem_valid,
  output logic             mem_wb_valid,
  output logic             retire,
  output logic             redirect_misaligned,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_FREEZE      = 2'd1,
    ST_FREEZE_PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [31:0]       r_pend_pc;
  logic [31:0]       r_pc;
  logic              r_if_id_valid;
  logic              r_id_ex_valid;
  logic              r_ex_mem_valid;
  logic              r_mem_wb_valid;
  logic              r_misaligned;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [CNT_W-1:0]  r_freeze_cnt;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic              w_run;
  logic              w_apply_pend;
  logic              w_redir;
  logic [31:0]       w_tgt;
  logic              w_flush;
  logic              w_stall;
  logic              w_miss;
  logic              w_adv;
  logic              w_retire;

  // Saturating increment: counters park at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  // Classify this cycle: exactly one of flush/stall/miss/advance when running, none when frozen or in reset.
  always_comb begin
    w_run        = rst_n & ~mem_busy;
    w_apply_pend = (r_state == ST_FREEZE_PEND) & ~mem_busy;
    w_redir      = w_run & (redirect_valid | w_apply_pend);
    // A live redirect in the release cycle is newer than the latched one, so it wins.
    w_tgt        = redirect_valid ? redirect_pc : r_pend_pc;
    w_flush      = w_run & (flush_req | w_redir);
    w_stall      = w_run & ~w_flush & stall_req;
    w_miss       = w_run & ~w_flush & ~w_stall & ~imem_ready;
    w_adv        = w_run & ~w_flush & ~w_stall & imem_ready;
    w_retire     = r_mem_wb_valid & ~mem_busy;
  end

  // Freeze tracking FSM with the pending-redirect latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_pend_pc <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (mem_busy) begin
            if (redirect_valid) begin
              r_state   <= ST_FREEZE_PEND;
              r_pend_pc <= redirect_pc;
            end else begin
              r_state <= ST_FREEZE;
            end
          end
        end
        ST_FREEZE: begin
          if (!mem_busy) begin
            r_state <= ST_RUN;
          end else if (redirect_valid) begin
            r_state   <= ST_FREEZE_PEND;
            r_pend_pc <= redirect_pc;
          end
        end
        ST_FREEZE_PEND: begin
          if (!mem_busy) begin
            r_state <= ST_RUN;
          end else if (redirect_valid) begin
            r_pend_pc <= redirect_pc;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Fetch PC: redirect target on flush, hold on stall/miss/freeze, else next sequential word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_flush) begin
      r_pc <= w_redir ? w_tgt : (r_pc + 32'd4);
    end else if (w_adv) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Stage valid bits: bubbles enter at IF/ID (miss/flush) or ID/EX (stall/flush); older stages always drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id_valid  <= 1'b0;
      r_id_ex_valid  <= 1'b0;
      r_ex_mem_valid <= 1'b0;
      r_mem_wb_valid <= 1'b0;
    end else if (w_run) begin
      r_ex_mem_valid <= r_id_ex_valid;
      r_mem_wb_valid <= r_ex_mem_valid;
      if (w_flush) begin
        r_if_id_valid <= 1'b0;
        r_id_ex_valid <= 1'b0;
      end else if (w_stall) begin
        r_id_ex_valid <= 1'b0;
      end else begin
        r_if_id_valid <= w_adv;
        r_id_ex_valid <= r_if_id_valid;
      end
    end
  end

  // Sticky flag for any applied redirect whose target is not word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misaligned <= 1'b0;
    end else if (w_redir && (w_tgt[1:0] != 2'b00)) begin
      r_misaligned <= 1'b1;
    end
  end

  // Saturating event counters; a flush cycle counts once and swallows any stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_stall)  r_stall_cnt  <= sat_inc(r_stall_cnt);
      if (w_flush)  r_flush_cnt  <= sat_inc(r_flush_cnt);
      if (mem_busy) r_freeze_cnt <= sat_inc(r_freeze_cnt);
      if (w_retire) r_retire_cnt <= sat_inc(r_retire_cnt);
    end
  end

  // Enables follow the cycle class; IF/ID loads a bubble on miss/flush but holds on stall.
  always_comb begin
    pc_en     = w_flush | w_adv;
    if_id_en  = w_run & ~w_stall;
    id_ex_en  = w_run;
    ex_mem_en = w_run;
    mem_wb_en = w_run;
  end

  assign pc_q                = r_pc;
  assign if_id_valid         = r_if_id_valid;
  assign id_ex_valid         = r_id_ex_valid;
  assign ex_mem_valid        = r_ex_mem_valid;
  assign mem_wb_valid        = r_mem_wb_valid;
  assign retire              = w_retire;
  assign redirect_misaligned = r_misaligned;
  assign stall_cnt           = r_stall_cnt;
  assign flush_cnt           = r_flush_cnt;
  assign freeze_cnt          = r_freeze_cnt;
  assign retire_cnt          = r_retire_cnt;

  // A frozen pipeline must never load any stage register.
  a_frozen_no_en: assert property (@(posedge clk) disable iff (!rst_n)
    mem_busy |-> !(pc_en || if_id_en || id_ex_en || ex_mem_en || mem_wb_en));

  // Stall and flush are mutually exclusive cycle classes.
  a_stall_flush_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_stall && w_flush));

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Sequential controller that consumes the hazard detector's stall/flush requests and drives the 5-stage pipeline.
- Owns the fetch PC and per-stage valid bits for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Drives register enables and bubble insertion.
- Absorbs redirects that arrive during a memory freeze and applies them once the freeze releases.
- Keeps saturating performance counters.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
stall_req  in  1  load-use stall request (hold PC and IF/ID, bubble into ID/EX)
flush_req  in  1  control-hazard flush (kill IF/ID and ID/EX contents)
redirect_valid  in  1  PC redirect request (branch taken, JAL, JALR)
redirect_pc  in  32  redirect target
imem_ready  in  1  instruction word valid this cycle
mem_busy  in  1  data memory wait; freezes the whole pipeline
pc_q  out  32  current fetch PC
pc_en  out  1  PC register updating this cycle
if_id_en  out  1  IF/ID load enable
id_ex_en  out  1  ID/EX load enable
ex_mem_en  out  1  EX/MEM load enable
mem_wb_en  out  1  MEM/WB load enable
if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid  out  1 each  stage holds a live instruction
retire  out  1  mem_wb_valid and not frozen (one pulse per retired instruction)
redirect_misaligned  out  1  sticky; set if an applied redirect_pc[1:0] != 0
stall_cnt, flush_cnt, freeze_cnt, retire_cnt  out  CNT_W each  saturating event counters

Behaviour:
Reset (rst_n low, asynchronous):
- pc_q = RESET_PC.
- All valid bits 0, all counters 0, redirect_misaligned 0.
- State RUN, pending redirect cleared.
- Enables are combinational outputs; during reset they evaluate to 0.

States:
- RUN: normal operation.
- FREEZE: mem_busy high, no redirect pending.
- FREEZE_PEND: mem_busy high, redirect latched.

Transitions:
- RUN -> FREEZE: mem_busy=1 and redirect_valid=0.
- RUN -> FREEZE_PEND: mem_busy=1 and redirect_valid=1; latches redirect_pc.
- FREEZE -> FREEZE_PEND: redirect_valid=1 while frozen; latches the target.
- Further redirects in FREEZE_PEND overwrite the latch (last wins).
- FREEZE / FREEZE_PEND -> RUN: first cycle mem_busy=0. From FREEZE_PEND, the pending redirect is applied exactly as a flush+redirect in that cycle.

Freeze (any state with mem_busy=1):
- All enables 0; pc_q, valid bits and retire_cnt hold.
- freeze_cnt increments each frozen cycle.
- stall_req and flush_req are ignored (the hazard unit re-evaluates next cycle).

Per-cycle priority in RUN (or in the release cycle): flush/redirect > stall > fetch-miss > advance.

Flush (flush_req, redirect_valid, or applied pending redirect):
- if_id_valid<=0, id_ex_valid<=0.
- EX/MEM and MEM/WB advance normally.
- If a redirect is present: pc_q<=target; otherwise pc_q<=pc_q+4.
- flush_cnt+1, counted once per cycle.
- A simultaneous stall_req is dropped and stall_cnt is unchanged.

Stall:
- pc_en=0, if_id_en=0; pc_q and if_id_valid hold.
- id_ex_en=1 with id_ex_valid<=0 (bubble).
- ex_mem_valid<=id_ex_valid, mem_wb_valid<=ex_mem_valid.
- stall_cnt+1.

Fetch-miss (imem_ready=0, no flush, no stall):
- pc_q holds, if_id_valid<=0.
- Downstream stages advance.

Advance:
- pc_q<=pc_q+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- Valid bits shift: if_id_valid<=1, id_ex<=if_id, ex_mem<=id_ex, mem_wb<=ex_mem.
- All enables 1.

Outputs and counters:
- retire = mem_wb_valid & ~mem_busy; retire_cnt increments on retire.
- All counters saturate at all-ones and never wrap.
- redirect_misaligned is cleared only by reset. The target is loaded unmodified.

Reset mid-freeze with a pending redirect: the pending redirect is discarded and pc_q=RESET_PC.

Test Plan:
1. Reset release, imem_ready=1 for 6 cycles -> pc_q 0,4,8,...,0x18. All valid bits 1 after 4 cycles; retire first pulses in cycle 5; retire_cnt=2 after 6 cycles.
2. Steady state, stall_req=1 for 1 cycle at pc_q=0x20 -> pc_q stays 0x20 one cycle, id_ex_valid=0 next cycle, stall_cnt=1, if_id_valid stays 1.
3. stall_req=1 and redirect_valid=1 (redirect_pc=0x100) same cycle -> next pc_q=0x100, if_id_valid=id_ex_valid=0, flush_cnt=1, stall_cnt=0.
4. mem_busy=1 for 3 cycles with redirect_valid=1 (pc=0x200) in the second frozen cycle -> pc_q frozen, freeze_cnt=3. Release cycle loads 0x200 and flushes IF/ID and ID/EX; flush_cnt=1.
5. rst_n deasserted asynchronously in FREEZE_PEND mid-cycle -> pc_q=RESET_PC immediately. After release, no redirect is applied and the state is RUN.
6. redirect_pc=0x102 -> pc_q=0x102, redirect_misaligned=1 and stays 1 after later aligned redirects. Separately, force stall_cnt to 16'hFFFF and stall again -> stays 16'hFFFF.
